// File: rtl/branch_seq_pkg.sv
// -----------------------------------------------------------------------------
// branch_seq_pkg
// Shared constants, state encoding and immediate decoding for the serial
// branch-resolution sequencer.
//   OPC_BRANCH     : SB-type major opcode
//   F3_*           : SB-type funct3 codes (beq/bne/blt/bge/bltu/bgeu)
//   state_t        : sequencer state encoding
//   imm_b()        : 32-bit sign-extended SB-type immediate of an instruction
// -----------------------------------------------------------------------------
package branch_seq_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUB     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Offset bits are scattered across the word; bit 0 is always zero.
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_slice_adder.sv
// -----------------------------------------------------------------------------
// branch_slice_adder
// Plain SLICE_W-bit ripple adder with carry in/out. The parent feeds the
// inverted subtrahend slice so that successive slices form rs1 - rs2.
//   a, b : slice operands
//   ci   : carry in
//   s    : slice sum
//   co   : carry out
// -----------------------------------------------------------------------------
module branch_slice_adder #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// branch_seq_ctrl
// Multicycle branch resolver. Accepts one request, computes rs1 - rs2 one
// slice per cycle through a single narrow adder, resolves taken/not-taken
// for the SB-type funct3 codes and returns the redirect decision and the
// next-PC target.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush                      : synchronous abort of the in-flight request
//   req_valid / req_ready      : request handshake
//   Instruction, rs1Data,
//   rs2Data, PC                : request payload
//   resp_valid / resp_ready    : response handshake
//   Branch, Target, Illegal    : response payload (held until handshake)
//   busy                       : sequencer not idle
// -----------------------------------------------------------------------------
module branch_seq_ctrl
    import branch_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic [XLEN-1:0] PC,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            Branch,
    output logic [XLEN-1:0] Target,
    output logic            Illegal,
    output logic            busy
);

    localparam int N     = XLEN / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    state_t            state;

    // Request fields kept only as far as resolution needs them.
    logic              is_sb_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   pc_q;

    // Serial subtraction state.
    logic [CNT_W-1:0]  cnt;
    logic              carry;
    logic              zacc;     // any nonzero difference bit seen so far
    logic              sum_msb;  // MSB of the latest slice; sum[XLEN-1] after the last

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_co;

    logic               a_msb;
    logic               b_msb;
    logic               is_lt;
    logic               is_ltu;
    logic               branch_nxt;
    logic               illegal_nxt;
    logic [XLEN-1:0]    target_nxt;

    assign req_ready = rst_n & (state == ST_IDLE) & ~flush;
    assign busy      = (state != ST_IDLE);

    assign a_slice = rs1_q[int'(cnt)*SLICE_W +: SLICE_W];
    assign b_slice = ~rs2_q[int'(cnt)*SLICE_W +: SLICE_W];

    branch_slice_adder #(
        .SLICE_W (SLICE_W)
    ) u_slice_adder (
        .a  (a_slice),
        .b  (b_slice),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    // Signed/unsigned less-than from operand sign bits and the difference MSB:
    // differing signs decide directly, equal signs defer to the sign of a - b.
    // NOTE: every always_comb output gets a default first so no path can
    //       leave it unassigned and infer a latch.
    always_comb begin
        a_msb       = rs1_q[XLEN-1];
        b_msb       = rs2_q[XLEN-1];
        is_lt       = (a_msb & ~b_msb) | ((a_msb ~^ b_msb) & sum_msb);
        is_ltu      = (~a_msb & b_msb) | ((a_msb ~^ b_msb) & sum_msb);
        branch_nxt  = 1'b0;
        illegal_nxt = 1'b0;
        if (is_sb_q) begin
            case (funct3_q)
                F3_BEQ:  branch_nxt = ~zacc;
                F3_BNE:  branch_nxt = zacc;
                F3_BLT:  branch_nxt = is_lt;
                F3_BGE:  branch_nxt = ~is_lt;
                F3_BLTU: branch_nxt = is_ltu;
                F3_BGEU: branch_nxt = ~is_ltu;
                default: illegal_nxt = 1'b1;
            endcase
        end
        target_nxt = branch_nxt ? (pc_q + imm_q) : (pc_q + XLEN'(4));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register samples pre-edge values regardless of statement order.
    // NOTE: the operand/PC holding registers are reset too; they are a few
    //       flops, not a memory array, and a known value keeps outputs clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            is_sb_q    <= 1'b0;
            funct3_q   <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            zacc       <= 1'b0;
            sum_msb    <= 1'b0;
            resp_valid <= 1'b0;
            Branch     <= 1'b0;
            Target     <= '0;
            Illegal    <= 1'b0;
        end else if (flush) begin
            // Abort wins over both handshakes; the request is dropped silently.
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_sb_q  <= (Instruction[6:0] == OPC_BRANCH);
                        funct3_q <= Instruction[14:12];
                        imm_q    <= XLEN'(signed'(imm_b(Instruction)));
                        rs1_q    <= rs1Data;
                        rs2_q    <= rs2Data;
                        pc_q     <= PC;
                        if (Instruction[6:0] == OPC_BRANCH) begin
                            state <= ST_SUB;
                            cnt   <= '0;
                            carry <= 1'b1;   // +1 completes the two's-complement negate
                            zacc  <= 1'b0;
                        end else begin
                            state <= ST_RESOLVE;
                        end
                    end
                end
                ST_SUB: begin
                    carry   <= slice_co;
                    zacc    <= zacc | (|slice_sum);
                    sum_msb <= slice_sum[SLICE_W-1];
                    if (cnt == LAST_SLICE) begin
                        state <= ST_RESOLVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    Branch     <= branch_nxt;
                    Target     <= target_nxt;
                    Illegal    <= illegal_nxt;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_seq_ctrl
// Directed bench for branch_seq_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_branch_seq_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     Instruction;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] PC;
    logic            resp_valid;
    logic            resp_ready;
    logic            Branch;
    logic [XLEN-1:0] Target;
    logic            Illegal;
    logic            busy;

    int passed = 0;
    int total  = 0;

    branch_seq_ctrl #(
        .XLEN    (XLEN),
        .SLICE_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .Instruction (Instruction),
        .rs1Data     (rs1Data),
        .rs2Data     (rs2Data),
        .PC          (PC),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .Branch      (Branch),
        .Target      (Target),
        .Illegal     (Illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge.
    task automatic accept(input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc);
        Instruction = instr;
        rs1Data     = a;
        rs2Data     = b;
        PC          = pc;
        req_valid   = 1'b1;
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Edges after the accept edge until resp_valid; -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("idle_after_handshake", {30'd0, resp_valid, busy}, 32'd0);
    endtask

    task automatic run_req(input string tag, input logic [31:0] instr,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input int exp_lat,
                           input logic exp_br, input logic [31:0] exp_tgt,
                           input logic exp_ill);
        int lat;
        accept(instr, a, b, pc);
        wait_resp(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_branch"},  {31'd0, Branch},  {31'd0, exp_br});
        check({tag, "_target"},  Target, exp_tgt);
        check({tag, "_illegal"}, {31'd0, Illegal}, {31'd0, exp_ill});
        consume();
    endtask

    initial begin
        int pulses;
        int lat;

        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        Instruction = '0;
        rs1Data     = '0;
        rs2Data     = '0;
        PC          = '0;

        // Reset state.
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_flags", {29'd0, busy, resp_valid, Branch}, 32'd0);
        check("rst_target", Target, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // beq equal, 5-cycle latency.
        run_req("beq_eq", 32'h0020_8463, 32'h1234_5678, 32'h1234_5678, 32'h100,
                5, 1'b1, 32'h108, 1'b0);
        // beq differing only in the top slice -> not taken.
        run_req("beq_ne", 32'h0020_8463, 32'h0100_0000, 32'h0, 32'h180,
                5, 1'b0, 32'h184, 1'b0);
        // bne differing only in a middle slice -> taken.
        run_req("bne_mid", 32'h0020_9463, 32'h0001_0000, 32'h0, 32'h1C0,
                5, 1'b1, 32'h1C8, 1'b0);
        // blt vs bltu on -1 and 1.
        run_req("blt", 32'h0020_C463, 32'hFFFF_FFFF, 32'h1, 32'h300,
                5, 1'b1, 32'h308, 1'b0);
        run_req("bltu", 32'h0020_E463, 32'hFFFF_FFFF, 32'h1, 32'h300,
                5, 1'b0, 32'h304, 1'b0);
        // bge equal operands, offset -4 from PC 0 wraps.
        run_req("bge_wrap", 32'hFE20_DEE3, 32'h5, 32'h5, 32'h0,
                5, 1'b1, 32'hFFFF_FFFC, 1'b0);
        // Non-SB instruction: 1-cycle latency.
        run_req("non_sb", 32'h0000_0013, 32'h0, 32'h0, 32'h200,
                1, 1'b0, 32'h204, 1'b0);
        // SB opcode, funct3 = 2 -> illegal.
        run_req("illegal_f3", 32'h0020_A463, 32'h7, 32'h7, 32'h400,
                5, 1'b0, 32'h404, 1'b1);

        // flush on the 2nd SUB cycle.
        accept(32'h0020_8463, 32'h1, 32'h1, 32'h600);
        step();
        flush = 1'b1;
        #1;
        check("flush_busy_during", {31'd0, busy}, 32'd1);
        check("flush_req_ready_masked", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_idle", {30'd0, busy, resp_valid}, 32'd0);
        check("flush_req_ready", {31'd0, req_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_valid) pulses++;
        end
        check("flush_no_resp", 32'(pulses), 32'd0);

        // Reset asserted while in SUB.
        accept(32'h0020_9463, 32'h3, 32'h4, 32'h700);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {27'd0, busy, resp_valid, Branch, Illegal, req_ready}, 32'd0);
        check("rst_mid_target", Target, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_recover", {31'd0, req_ready}, 32'd1);

        // Backpressure: response held for 10 cycles.
        accept(32'h0020_8463, 32'hCAFE_0001, 32'hCAFE_0001, 32'h500);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_flags", {29'd0, resp_valid, Branch, req_ready}, 32'b110);
            check("bp_hold_target", Target, 32'h508);
        end
        consume();
        check("bp_req_ready", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
